// File: rtl/dmem_access_arbiter_if.sv
// Bus bundle for dmem_access_arbiter: the CPU MEM-stage port, the external
// (debug/loader) port and the single-port data memory bus.
// The master modport is the arbiter's view. The slave modport is the
// environment's view (pipeline, EXT requester, memory).
interface dmem_access_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   // CPU MEM-stage port
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_stall;
   // external requester port
   logic          ext_req;
   logic          ext_we;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata;
   logic          ext_gnt;
   logic          ext_rvalid;
   logic [DW-1:0] ext_rdata;
   // data memory bus
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   // status
   logic          busy;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cpu_rdata, cpu_stall,
      input  ext_req, ext_we, ext_addr, ext_wdata,
      output ext_gnt, ext_rvalid, ext_rdata,
      output mem_we, mem_addr, mem_wdata,
      input  mem_rdata,
      output busy
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cpu_rdata, cpu_stall,
      output ext_req, ext_we, ext_addr, ext_wdata,
      input  ext_gnt, ext_rvalid, ext_rdata,
      input  mem_we, mem_addr, mem_wdata,
      output mem_rdata,
      input  busy
   );
endinterface

// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter: shares one single-port data memory between the CPU
// MEM stage and an external requester.
//
// Each access follows the sequence IDLE -> ACC (LAT cycles) -> RESP -> IDLE.
// - The memory bus is held for LAT cycles.
// - Write enable and read capture happen only in the last ACC cycle.
// - The CPU is stalled until RESP. EXT gets a grant pulse and later a
//   completion pulse.
//
// Optional feature, selected by the macro DMEM_ARB_RR_EN:
// - undefined: fixed priority, and the CPU wins any contention.
// - defined: round-robin arbitration between CPU and EXT.
module dmem_access_arbiter #(
   parameter int AW  = 32,
   parameter int DW  = 32,
   parameter int LAT = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   dmem_access_arbiter_if.master io_bus
);

   localparam int CW = $clog2(LAT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_EXT = 1'b1
   } owner_t;

   state_t        r_state;
   state_t        w_next_state;
   owner_t        r_owner;
   owner_t        w_winner;
   logic [CW-1:0] r_cnt;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_cpu_rdata;
   logic [DW-1:0] r_ext_rdata;
   logic          w_any_req;
   logic          w_grant;
   logic          w_last_acc;

   assign w_any_req  = io_bus.cpu_req | io_bus.ext_req;
   assign w_grant    = (r_state == S_IDLE) & w_any_req;
   assign w_last_acc = (r_state == S_ACC) & (r_cnt == '0);

`ifdef DMEM_ARB_RR_EN
   owner_t r_last_grant;

   // Round-robin winner: on contention, the side not granted last time wins.
   always_comb begin
      if (io_bus.cpu_req && io_bus.ext_req) begin
         w_winner = (r_last_grant == OWN_CPU) ? OWN_EXT : OWN_CPU;
      end else if (io_bus.ext_req) begin
         w_winner = OWN_EXT;
      end else begin
         w_winner = OWN_CPU;
      end
   end

   // Remember which side received the most recent grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last_grant <= OWN_CPU;
      end else if (w_grant) begin
         r_last_grant <= w_winner;
      end
   end
`else
   // Fixed priority: the CPU wins whenever it requests, so EXT may starve.
   always_comb begin
      w_winner = io_bus.cpu_req ? OWN_CPU : OWN_EXT;
   end
`endif

   // State register.
   // NOTE: clocked state always uses non-blocking assignments, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic. RESP always returns to IDLE; no arbitration happens there.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         S_IDLE:  if (w_any_req) w_next_state = S_ACC;
         S_ACC:   if (r_cnt == '0) w_next_state = S_RESP;
         S_RESP:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Per-access registers: latch the winner at grant, count down in ACC,
   // and capture read data for the owner in the last ACC cycle.
   // NOTE: every latched register is reset, so an access aborted by reset
   // leaves nothing stale to drive onto the bus afterwards.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner     <= OWN_CPU;
         r_cnt       <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_rdata <= '0;
         r_ext_rdata <= '0;
      end else if (w_grant) begin
         r_owner <= w_winner;
         r_cnt   <= CW'(LAT - 1);
         if (w_winner == OWN_CPU) begin
            r_we    <= io_bus.cpu_we;
            r_addr  <= io_bus.cpu_addr;
            r_wdata <= io_bus.cpu_wdata;
         end else begin
            r_we    <= io_bus.ext_we;
            r_addr  <= io_bus.ext_addr;
            r_wdata <= io_bus.ext_wdata;
         end
      end else if (r_state == S_ACC) begin
         if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
         end else if (r_owner == OWN_CPU) begin
            r_cpu_rdata <= io_bus.mem_rdata;
         end else begin
            r_ext_rdata <= io_bus.mem_rdata;
         end
      end
   end

   // Output decode. The bus is driven only in ACC, and mem_we only in the
   // final ACC cycle. Input-driven pulses are held low while reset is asserted.
   // NOTE: every output gets a default before the case, so no latch is inferred.
   always_comb begin
      io_bus.mem_we     = 1'b0;
      io_bus.mem_addr   = '0;
      io_bus.mem_wdata  = '0;
      io_bus.ext_gnt    = 1'b0;
      io_bus.ext_rvalid = 1'b0;
      io_bus.cpu_stall  = io_bus.cpu_req & ~rst;
      io_bus.cpu_rdata  = r_cpu_rdata;
      io_bus.ext_rdata  = r_ext_rdata;
      io_bus.busy       = (r_state != S_IDLE);
      unique case (r_state)
         S_IDLE: begin
            io_bus.ext_gnt = io_bus.ext_req & (w_winner == OWN_EXT) & ~rst;
         end
         S_ACC: begin
            io_bus.mem_addr  = r_addr;
            io_bus.mem_wdata = r_wdata;
            io_bus.mem_we    = r_we & w_last_acc;
         end
         S_RESP: begin
            if (r_owner == OWN_CPU) begin
               io_bus.cpu_stall = 1'b0;
            end else begin
               io_bus.ext_rvalid = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_access_arbiter.sv
// Self-checking bench for dmem_access_arbiter.
//
// The reference model works at transaction level:
// - It picks the winner with the arbitration rule.
// - The first-served access starts at cycle 0. The other starts once the
//   first has completed (LAT+2 cycles later).
// - Expected read data comes from a reference memory updated in service order.
module tb_dmem_access_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int LAT     = 3;
   localparam int OWN_CPU = 0;
   localparam int OWN_EXT = 1;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dmem_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dmem_access_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );

   // Physical memory seen by the DUT: combinational read, clocked write.
   logic [DW-1:0] phys_mem [64];
   // Reference model memory.
   logic [DW-1:0] ref_mem  [64];

   assign bus.mem_rdata = phys_mem[bus.mem_addr[7:2]];

   always @(posedge clk) begin
      if (bus.mem_we) phys_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
   end

   int n_tests = 0;
   int n_fail  = 0;
`ifdef DMEM_ARB_RR_EN
   int last_grant = OWN_CPU;
`endif

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int pick_winner(input bit c, input bit e);
      if (c && e) begin
`ifdef DMEM_ARB_RR_EN
         return (last_grant == OWN_CPU) ? OWN_EXT : OWN_CPU;
`else
         return OWN_CPU;
`endif
      end
      return e ? OWN_EXT : OWN_CPU;
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      return AW'($urandom_range(0, 15) * 4);
   endfunction

   // One arbitration episode that starts with the DUT in IDLE.
   // c_dly raises the CPU request one cycle late, so EXT wins alone first.
   task automatic txn(input bit c_on, input bit c_dly, input bit c_we,
                      input logic [AW-1:0] c_addr, input logic [DW-1:0] c_wd,
                      input bit e_on, input bit e_we,
                      input logic [AW-1:0] e_addr, input logic [DW-1:0] e_wd);
      int win, who, start, n_wr, exp_cpu_rel, exp_gnt, exp_rv;
      int cpu_rel, gnt, rv, n_gnt, n_rv, n_we;
      bit on, done;
      logic [DW-1:0] exp_c, exp_e;
      n_wr = 0; exp_cpu_rel = -1; exp_gnt = -1; exp_rv = -1;
      cpu_rel = -1; gnt = -1; rv = -1; n_gnt = 0; n_rv = 0; n_we = 0;
      done = 1'b0; exp_c = '0; exp_e = '0;
      win = (c_on && c_dly && e_on) ? OWN_EXT : pick_winner(c_on, e_on);
      for (int s = 0; s < 2; s++) begin
         who   = (s == 0) ? win : 1 - win;
         on    = (who == OWN_CPU) ? c_on : e_on;
         start = s * (LAT + 2);
         if (on) begin
`ifdef DMEM_ARB_RR_EN
            last_grant = who;
`endif
            if (who == OWN_CPU) begin
               exp_cpu_rel = start + LAT + 1;
               exp_c = ref_mem[c_addr[7:2]];
               if (c_we) begin ref_mem[c_addr[7:2]] = c_wd; n_wr++; end
            end else begin
               exp_gnt = start;
               exp_rv  = start + LAT + 1;
               exp_e = ref_mem[e_addr[7:2]];
               if (e_we) begin ref_mem[e_addr[7:2]] = e_wd; n_wr++; end
            end
         end
      end
      bus.cpu_req = c_on && !c_dly; bus.cpu_we = c_we; bus.cpu_addr = c_addr; bus.cpu_wdata = c_wd;
      bus.ext_req = e_on; bus.ext_we = e_we; bus.ext_addr = e_addr; bus.ext_wdata = e_wd;
      for (int cyc = 0; cyc < 2 * (LAT + 2) + 6; cyc++) begin
         @(negedge clk);
         if (cyc == 0) check("busy_idle", 64'(bus.busy), 64'd0);
         if (bus.mem_we) n_we++;
         if (bus.ext_gnt) begin n_gnt++; if (gnt < 0) gnt = cyc; end
         if (bus.ext_rvalid) begin
            n_rv++;
            if (rv < 0) begin
               rv = cyc;
               if (!e_we) check("ext_rdata", 64'(bus.ext_rdata), 64'(exp_e));
            end
         end
         if (bus.cpu_req && !bus.cpu_stall && cpu_rel < 0) begin
            cpu_rel = cyc;
            if (!c_we) check("cpu_rdata", 64'(bus.cpu_rdata), 64'(exp_c));
         end
         done = (!c_on || cpu_rel >= 0) && (!e_on || rv >= 0);
         step();
         if (cpu_rel == cyc) begin bus.cpu_req = 1'b0; bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; end
         if (c_on && c_dly && cyc == 0) bus.cpu_req = 1'b1;
         if (gnt == cyc) begin bus.ext_req = 1'b0; bus.ext_addr = $urandom; bus.ext_wdata = $urandom; end
         if (done) break;
      end
      bus.cpu_req = 1'b0;
      bus.ext_req = 1'b0;
      check("txn_complete", 64'(done), 64'd1);
      if (c_on) check("cpu_release_cycle", 64'(cpu_rel), 64'(exp_cpu_rel));
      check("ext_gnt_cycle", 64'(gnt), 64'(exp_gnt));
      check("ext_rvalid_cycle", 64'(rv), 64'(exp_rv));
      check("ext_gnt_pulses", 64'(n_gnt), 64'(e_on ? 1 : 0));
      check("ext_rvalid_pulses", 64'(n_rv), 64'(e_on ? 1 : 0));
      check("mem_we_cycles", 64'(n_we), 64'(n_wr));
   endtask

   initial begin
      int n_g, n_r, exp_ext, w, mode, n_we;
      rst = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
      for (int i = 0; i < 64; i++) begin
         phys_mem[i] = $urandom;
         ref_mem[i]  = phys_mem[i];
      end
      phys_mem[4] = 32'hDEADBEEF;
      ref_mem[4]  = 32'hDEADBEEF;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_cpu_stall", 64'(bus.cpu_stall), 64'd0);
      check("rst_ext_gnt", 64'(bus.ext_gnt), 64'd0);
      check("rst_ext_rvalid", 64'(bus.ext_rvalid), 64'd0);
      check("rst_mem_we", 64'(bus.mem_we), 64'd0);
      check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
      check("rst_cpu_rdata", 64'(bus.cpu_rdata), 64'd0);
      check("rst_ext_rdata", 64'(bus.ext_rdata), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      step();
      rst = 1'b0;

      // CPU load of a known word
      txn(1, 0, 0, 32'h10, '0, 0, 0, '0, '0);
      // CPU store, then reload the same address
      txn(1, 0, 1, 32'h20, 32'h12345678, 0, 0, '0, '0);
      txn(1, 0, 0, 32'h20, '0, 0, 0, '0, '0);

      // Reset during the ACC phase of a store, before its final ACC cycle
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h24; bus.cpu_wdata = 32'hCAFEF00D;
      n_we = 0;
      for (int cyc = 0; cyc < LAT; cyc++) begin
         @(negedge clk);
         if (bus.mem_we) n_we++;
         if (cyc < LAT - 1) step();
      end
      rst = 1'b1;
      bus.cpu_req = 1'b0;
      #1;
      check("abort_mem_we_cycles", 64'(n_we), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_mem_we", 64'(bus.mem_we), 64'd0);
      check("abort_mem_addr", 64'(bus.mem_addr), 64'd0);
      check("abort_cpu_stall", 64'(bus.cpu_stall), 64'd0);
      check("abort_ext_rvalid", 64'(bus.ext_rvalid), 64'd0);
      step();
      check("abort_mem_unchanged", 64'(phys_mem[9]), 64'(ref_mem[9]));
      rst = 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_grant = OWN_CPU;
`endif
      txn(1, 0, 0, 32'h24, '0, 0, 0, '0, '0);

      // Simultaneous CPU and EXT requests
      txn(1, 0, 0, 32'h30, '0, 1, 0, 32'h34, '0);

      // EXT write while the CPU requests during it, then read back from both sides
      txn(1, 1, 0, 32'h44, '0, 1, 1, 32'h40, 32'hA5A5A5A5);
      txn(1, 0, 0, 32'h40, '0, 0, 0, '0, '0);
      txn(0, 0, 0, '0, '0, 1, 0, 32'h40, '0);

      // Both sides requesting continuously for six accesses
      exp_ext = 0;
      for (int k = 0; k < 6; k++) begin
         w = pick_winner(1, 1);
`ifdef DMEM_ARB_RR_EN
         last_grant = w;
`endif
         if (w == OWN_EXT) exp_ext++;
      end
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h50;
      bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h54;
      n_g = 0; n_r = 0;
      for (int i = 0; i < 6 * (LAT + 2); i++) begin
         @(negedge clk);
         if (bus.ext_gnt) n_g++;
         if (!bus.cpu_stall) n_r++;
         step();
      end
      bus.cpu_req = 1'b0;
      bus.ext_req = 1'b0;
      check("contention_ext_gnts", 64'(n_g), 64'(exp_ext));
      check("contention_cpu_releases", 64'(n_r), 64'(6 - exp_ext));

      // Randomized episodes
      for (int t = 0; t < 25; t++) begin
         mode = $urandom_range(0, 3);
         txn(mode != 1, mode == 3, 1'($urandom), rand_addr(), $urandom,
             mode != 0, 1'($urandom), rand_addr(), $urandom);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
